pc_pass_monitor: RTL and testbench

- Synthesizable, multi-signature test-completion monitor attached to cpu_top's stage-1 PC (pc_current_s1).
- Watches the PC stream for any of NUM_CH programmed (last_addr -> pass_addr) transitions.
- Also supports a pass_addr-only fallback mode per entry, plus a runtime cycle timeout.
- Reports pass, fail or timeout with a cycle count, so one bench or FPGA wrapper can run the whole rv32ui load/store suite without per-test case statements.

---
 rtl/mon_pkg.sv | 22 ++
 rtl/mon_sig_match.sv | 21 ++
 rtl/pc_pass_monitor.sv | 162 ++++++++++++++++
 tb/tb_pc_pass_monitor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mon_pkg.sv
// Shared types for the PC pass monitor: FSM state encoding and the signature entry layout.
package mon_pkg;

  localparam int unsigned MON_XLEN  = 32;
  localparam int unsigned MON_CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } mon_state_e;

  typedef struct packed {
    logic                valid;
    logic                any_prev;
    logic [MON_XLEN-1:0] pass_addr;
    logic [MON_XLEN-1:0] last_addr;
  } mon_sig_t;

endpackage

// File: rtl/mon_sig_match.sv
// Combinational match of one (last_addr -> pass_addr) signature against the current PC sample.
module mon_sig_match
  import mon_pkg::*;
#(
  parameter int unsigned XLEN = MON_XLEN
) (
  input  mon_sig_t         i_sig,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_prev_pc,
  input  logic             i_pc_valid,
  output logic             o_match
);

  logic w_pass_hit;
  logic w_prev_ok;

  assign w_pass_hit = (i_pc == i_sig.pass_addr);
  assign w_prev_ok  = i_sig.any_prev || (i_prev_pc == i_sig.last_addr);
  assign o_match    = i_sig.valid && i_pc_valid && w_pass_hit && w_prev_ok;

endmodule

// File: rtl/pc_pass_monitor.sv
// Test-completion monitor: watches the PC stream for programmed pass signatures, with cycle timeout.
// Optional hang detection is enabled by defining PC_STUCK_DETECT_EN.
module pc_pass_monitor
  import mon_pkg::*;
#(
  parameter int unsigned XLEN         = MON_XLEN,
  parameter int unsigned NUM_CH       = 16,
  parameter int unsigned CNT_W        = MON_CNT_W,
  parameter int unsigned STUCK_CYCLES = 8,
  localparam int unsigned IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic              cfg_valid_i,
  input  logic              cfg_any_prev_i,
  input  logic [XLEN-1:0]   cfg_pass_addr_i,
  input  logic [XLEN-1:0]   cfg_last_addr_i,
  input  logic [CNT_W-1:0]  max_cycles_i,
  input  logic              start_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              pc_valid_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [IDX_W-1:0]  match_idx_o,
  output logic [CNT_W-1:0]  cycles_o
);

  mon_state_e        r_state;
  mon_sig_t          r_sig [NUM_CH];
  logic [XLEN-1:0]   r_prev_pc;
  logic [CNT_W-1:0]  r_cycles;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic              r_timeout;
  logic [IDX_W-1:0]  r_match_idx;

  logic [NUM_CH-1:0] w_match;
  logic              w_any;
  logic [IDX_W-1:0]  w_idx;
  logic [CNT_W-1:0]  w_cycles_n;
  logic              w_hang;
  logic              w_timeout_hit;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mon_sig_match #(.XLEN(XLEN)) u_match (
      .i_sig      (r_sig[g]),
      .i_pc       (pc_i),
      .i_prev_pc  (r_prev_pc),
      .i_pc_valid (pc_valid_i),
      .o_match    (w_match[g])
    );
  end

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    w_idx = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (w_match[i-1]) w_idx = IDX_W'(i - 1);
    end
  end

  assign w_any         = |w_match;
  assign w_cycles_n    = (&r_cycles) ? r_cycles : r_cycles + CNT_W'(1);
  assign w_timeout_hit = (max_cycles_i != '0) && (w_cycles_n == max_cycles_i);

`ifdef PC_STUCK_DETECT_EN
  localparam int unsigned STUCK_W = $clog2(STUCK_CYCLES + 1);

  logic [STUCK_W-1:0] r_stuck;
  logic [STUCK_W-1:0] w_stuck_n;

  always_comb begin
    w_stuck_n = r_stuck;
    if (pc_valid_i) begin
      if (pc_i != r_prev_pc)                           w_stuck_n = '0;
      else if (r_stuck != STUCK_W'(STUCK_CYCLES))      w_stuck_n = r_stuck + STUCK_W'(1);
    end
  end

  assign w_hang = (w_stuck_n >= STUCK_W'(STUCK_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_stuck <= '0;
    else if (start_i)           r_stuck <= '0;
    else if (r_state == S_RUN)  r_stuck <= w_stuck_n;
  end
`else
  logic w_unused_stuck;
  assign w_unused_stuck = (STUCK_CYCLES == 0);
  assign w_hang         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) r_sig[i] <= '0;
    end else if (cfg_we_i) begin
      r_sig[cfg_idx_i] <= '{valid:     cfg_valid_i,
                            any_prev:  cfg_any_prev_i,
                            pass_addr: cfg_pass_addr_i,
                            last_addr: cfg_last_addr_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prev_pc   <= '0;
      r_cycles    <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_match_idx <= '0;
    end else begin
      if (pc_valid_i) r_prev_pc <= pc_i;
      if (start_i) begin
        r_state     <= S_RUN;
        r_prev_pc   <= pc_i;
        r_cycles    <= '0;
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
        r_fail      <= 1'b0;
        r_timeout   <= 1'b0;
        r_match_idx <= '0;
      end else begin
        case (r_state)
          S_RUN: begin
            r_cycles <= w_cycles_n;
            if (w_any) begin
              r_state     <= S_PASS;
              r_done      <= 1'b1;
              r_pass      <= 1'b1;
              r_match_idx <= w_idx;
            end else if (w_hang) begin
              r_state <= S_FAIL;
              r_done  <= 1'b1;
              r_fail  <= 1'b1;
            end else if (w_timeout_hit) begin
              r_state   <= S_TIMEOUT;
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign fail_o      = r_fail;
  assign timeout_o   = r_timeout;
  assign match_idx_o = r_match_idx;
  assign cycles_o    = r_cycles;

endmodule

// File: tb/tb_pc_pass_monitor.sv
// Directed bench for pc_pass_monitor: signature match, fallback, timeout, stall, hang and reset.
module tb_pc_pass_monitor;
  import mon_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cfg_we_i;
  logic [3:0]  cfg_idx_i;
  logic        cfg_valid_i;
  logic        cfg_any_prev_i;
  logic [31:0] cfg_pass_addr_i;
  logic [31:0] cfg_last_addr_i;
  logic [31:0] max_cycles_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        done_o;
  logic        pass_o;
  logic        fail_o;
  logic        timeout_o;
  logic [3:0]  match_idx_o;
  logic [31:0] cycles_o;

  int checks = 0;
  int errors = 0;

  pc_pass_monitor #(
    .XLEN(32), .NUM_CH(16), .CNT_W(32), .STUCK_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_valid_i(cfg_valid_i),
    .cfg_any_prev_i(cfg_any_prev_i), .cfg_pass_addr_i(cfg_pass_addr_i),
    .cfg_last_addr_i(cfg_last_addr_i), .max_cycles_i(max_cycles_i),
    .start_i(start_i), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
    .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .match_idx_o(match_idx_o), .cycles_o(cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic d, input logic p, input logic f,
                           input logic t, input logic [31:0] cyc);
    check({tag, ".done"},    done_o,    d);
    check({tag, ".pass"},    pass_o,    p);
    check({tag, ".fail"},    fail_o,    f);
    check({tag, ".timeout"}, timeout_o, t);
    check({tag, ".cycles"},  cycles_o,  cyc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] idx, input logic v, input logic anyp,
                     input logic [31:0] pass_a, input logic [31:0] last_a);
    cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_valid_i = v; cfg_any_prev_i = anyp;
    cfg_pass_addr_i = pass_a; cfg_last_addr_i = last_a; pc_valid_i = 1'b0;
    tick;
    cfg_we_i = 1'b0;
  endtask

  task automatic start(input logic [31:0] pc);
    start_i = 1'b1; pc_i = pc; pc_valid_i = 1'b0;
    tick;
    start_i = 1'b0;
  endtask

  task automatic pcs(input logic [31:0] pc, input logic v);
    pc_i = pc; pc_valid_i = v;
    tick;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_valid_i = 1'b0;
    cfg_any_prev_i = 1'b0; cfg_pass_addr_i = '0; cfg_last_addr_i = '0;
    max_cycles_i = '0; start_i = 1'b0; pc_i = '0; pc_valid_i = 1'b0;
    #12;
    check_res("reset", 0, 0, 0, 0, 0);
    check("reset.idx", match_idx_o, 0);
    rst_n = 1'b1;
    tick;

    // lb signature through entry 3
    cfg(3, 1, 0, 32'h41C, 32'h404);
    max_cycles_i = 2000;
    start(32'h3FC);
    pcs(32'h400, 1);
    pcs(32'h404, 1);
    check_res("lb.pre", 0, 0, 0, 0, 2);
    pcs(32'h41C, 1);
    check_res("lb", 1, 1, 0, 0, 3);
    check("lb.idx", match_idx_o, 3);
    pcs(32'h500, 1);
    check_res("lb.sticky", 1, 1, 0, 0, 3);

    // wrong predecessor, then correct one
    cfg(5, 1, 0, 32'h1018, 32'h1000);
    start(32'h1010);
    check_res("restart", 0, 0, 0, 0, 0);
    check("restart.idx", match_idx_o, 0);
    pcs(32'h1014, 1);
    pcs(32'h1018, 1);
    check_res("wrongprev", 0, 0, 0, 0, 2);
    pcs(32'h1000, 1);
    pcs(32'h1018, 1);
    check_res("rightprev", 1, 1, 0, 0, 4);
    check("rightprev.idx", match_idx_o, 5);

    // fallback and lowest-index priority
    cfg(6, 1, 1, 32'h898, 32'h0);
    start(32'h0C);
    pcs(32'h10, 1);
    pcs(32'h898, 1);
    check_res("fallback", 1, 1, 0, 0, 2);
    check("fallback.idx", match_idx_o, 6);
    cfg(2, 1, 1, 32'h898, 32'h0);
    start(32'h10);
    pcs(32'h898, 1);
    check("prio.idx", match_idx_o, 2);

    // write to entry 2 in the matching cycle still sees the old entry
    start(32'h10);
    cfg_we_i = 1'b1; cfg_idx_i = 2; cfg_valid_i = 1'b0; cfg_any_prev_i = 1'b0;
    cfg_pass_addr_i = 32'h0; cfg_last_addr_i = 32'h0;
    pcs(32'h898, 1);
    cfg_we_i = 1'b0;
    check("wrsame.pass", pass_o, 1);
    check("wrsame.idx", match_idx_o, 2);
    start(32'h10);
    pcs(32'h898, 1);
    check("wrafter.idx", match_idx_o, 6);
    cfg(6, 0, 0, 32'h0, 32'h0);

    // timeout boundary: match on the max-th cycle wins
    max_cycles_i = 5;
    start(32'h100);
    pcs(32'h104, 1);
    pcs(32'h108, 1);
    pcs(32'h400, 1);
    pcs(32'h404, 1);
    pcs(32'h41C, 1);
    check_res("tmo.pass", 1, 1, 0, 0, 5);
    start(32'h100);
    pcs(32'h104, 1);
    pcs(32'h108, 1);
    pcs(32'h10C, 1);
    pcs(32'h110, 1);
    check_res("tmo.pre", 0, 0, 0, 0, 4);
    pcs(32'h114, 1);
    check_res("tmo", 1, 0, 0, 1, 5);
    pcs(32'h118, 1);
    check_res("tmo.sticky", 1, 0, 0, 1, 5);
    max_cycles_i = 0;
    start(32'h100);
    for (int i = 0; i < 10; i++) pcs(32'h104 + 32'(4 * i), 1);
    check_res("notmo", 0, 0, 0, 0, 10);

    // stall between predecessor and pass target
    cfg(4, 1, 0, 32'h47C, 32'h464);
    max_cycles_i = 2000;
    start(32'h460);
    pcs(32'h464, 1);
    pcs(32'h47C, 0);
    pcs(32'h47C, 0);
    pcs(32'h47C, 0);
    check_res("stall.pre", 0, 0, 0, 0, 4);
    pcs(32'h47C, 1);
    check_res("stall", 1, 1, 0, 0, 5);
    check("stall.idx", match_idx_o, 4);

    // hang at 0x200
    max_cycles_i = 20;
    start(32'h200);
    for (int i = 0; i < 7; i++) pcs(32'h200, 1);
    check_res("hang.pre", 0, 0, 0, 0, 7);
    pcs(32'h200, 1);
`ifdef PC_STUCK_DETECT_EN
    check_res("hang", 1, 0, 1, 0, 8);
`else
    check_res("hang.run", 0, 0, 0, 0, 8);
    for (int i = 0; i < 11; i++) pcs(32'h200, 1);
    check_res("hang.pre_tmo", 0, 0, 0, 0, 19);
    pcs(32'h200, 1);
    check_res("hang.tmo", 1, 0, 0, 1, 20);
`endif

    // reset mid-RUN, entries cleared
    max_cycles_i = 0;
    start(32'h400);
    pcs(32'h404, 1);
    pcs(32'h408, 1);
    #2 rst_n = 1'b0;
    #1;
    check_res("midrst", 0, 0, 0, 0, 0);
    check("midrst.idx", match_idx_o, 0);
    tick;
    rst_n = 1'b1;
    tick;
    start(32'h400);
    pcs(32'h404, 1);
    pcs(32'h41C, 1);
    check_res("cleared", 0, 0, 0, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
